// File: rtl/fabric_port_out_pkg.sv
// Shared types for the fabric-port-out write-side arbiter and its pick logic.
package fabric_port_out_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Index width that stays at least one bit even for degenerate sizes.
    function automatic int grant_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin pick: first asserted request at or above rr_ptr, wrapping.
module rr_arbiter_pick
    import fabric_port_out_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int GW = grant_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      rr_ptr,
    output logic [GW-1:0]      pick,
    output logic               any_req
);

    logic [GW-1:0] idx;

    // Scan downward in priority so the highest-priority hit is written last.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = GW'((int'(rr_ptr) + i) % NUM_REQ);
            if (req[idx]) pick = idx;
        end
        any_req = |req;
    end

endmodule

// File: rtl/fabric_port_out_arbiter.sv
// Packet-granular round-robin arbiter feeding the write port of the fabric-port-out FIFO.
module fabric_port_out_arbiter
    import fabric_port_out_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 36,
    parameter int CNT_W   = 16,
    localparam int GW = grant_w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       i_valid,
    input  logic [NUM_REQ*WIDTH-1:0] i_data,
    input  logic [NUM_REQ-1:0]       i_last,
    output logic [NUM_REQ-1:0]       i_ready,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_last,
    output logic                     o_write_en,
    input  logic                     o_ready,
    output logic [GW-1:0]            o_grant,
    output logic                     o_busy,
    output logic [CNT_W-1:0]         o_pkt_count
);

    arb_state_t       state;
    logic [GW-1:0]    rr_ptr;
    logic [GW-1:0]    grant;
    logic [GW-1:0]    pick;
    logic [GW-1:0]    sel;
    logic [GW-1:0]    next_ptr;
    logic             any_req;
    logic             sel_valid;
    logic             sel_last;
    logic             accept;
    logic [WIDTH-1:0] sel_data;

    rr_arbiter_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (i_valid),
        .rr_ptr  (rr_ptr),
        .pick    (pick),
        .any_req (any_req)
    );

    // While locked, only the owner may move, even if it is currently idle.
    always_comb begin
        sel       = (state == LOCK) ? grant : pick;
        sel_valid = (state == LOCK) ? i_valid[sel] : any_req;
        sel_data  = i_data[sel*WIDTH +: WIDTH];
        sel_last  = i_last[sel];
        next_ptr  = GW'((int'(sel) + 1) % NUM_REQ);
        accept    = sel_valid & o_ready & ~rst;
        i_ready   = '0;
        if (!rst && (state == LOCK || any_req))
            i_ready[sel] = o_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant       <= '0;
            o_write_en  <= 1'b0;
            o_data      <= '0;
            o_last      <= 1'b0;
            o_grant     <= '0;
            o_busy      <= 1'b0;
            o_pkt_count <= '0;
        end else begin
            o_write_en <= accept;
            if (accept) begin
                o_data  <= sel_data;
                o_last  <= sel_last;
                o_grant <= sel;
                if (sel_last) begin
                    state       <= IDLE;
                    o_busy      <= 1'b0;
                    rr_ptr      <= next_ptr;
                    o_pkt_count <= o_pkt_count + 1'b1;
                end else if (state == IDLE) begin
                    state  <= LOCK;
                    o_busy <= 1'b1;
                    grant  <= sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_fabric_port_out_arbiter.sv
// Scoreboard bench: per-requester packet queues drive the arbiter, expected FIFO words are checked in order.
module tb_fabric_port_out_arbiter;

    localparam int NR = 4;
    localparam int W  = 36;
    localparam int CW = 4;
    localparam int GW = 2;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        int           hold;
        int           idx;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   i_valid;
    logic [NR*W-1:0] i_data;
    logic [NR-1:0]   i_last;
    logic [NR-1:0]   i_ready;
    logic [W-1:0]    o_data;
    logic            o_last;
    logic            o_write_en;
    logic            o_ready;
    logic [GW-1:0]   o_grant;
    logic            o_busy;
    logic [CW-1:0]   o_pkt_count;

    fabric_port_out_arbiter #(.NUM_REQ(NR), .WIDTH(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_last      (i_last),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_last      (o_last),
        .o_write_en  (o_write_en),
        .o_ready     (o_ready),
        .o_grant     (o_grant),
        .o_busy      (o_busy),
        .o_pkt_count (o_pkt_count)
    );

    always #5 clk = ~clk;

    ent_t          rq[NR][$];
    ent_t          exp_q[$];
    int            hcnt[NR];
    logic [CW-1:0] exp_cnt;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            tk = 0;
    int            wr_cnt, first_wr, last_wr, rdy0_cnt, busy_cnt, blk_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input int k, input int n);
        return {4'(k), 32'(n)};
    endfunction

    task automatic drive();
        for (int k = 0; k < NR; k++) begin
            i_valid[k]        = (rq[k].size() > 0) && (hcnt[k] == 0);
            i_data[k*W +: W]  = (rq[k].size() > 0) ? rq[k][0].data : '0;
            i_last[k]         = (rq[k].size() > 0) ? rq[k][0].last : 1'b0;
        end
    endtask

    task automatic push(input int k, input logic [W-1:0] d, input logic l, input int hold);
        ent_t e;
        e.data = d; e.last = l; e.hold = hold; e.idx = k;
        if (rq[k].size() == 0) hcnt[k] = hold;
        rq[k].push_back(e);
        drive();
    endtask

    task automatic expect_wr(input int k, input logic [W-1:0] d, input logic l);
        ent_t e;
        e.data = d; e.last = l; e.hold = 0; e.idx = k;
        exp_q.push_back(e);
    endtask

    task automatic clr_stats();
        wr_cnt = 0; first_wr = -1; last_wr = -1; rdy0_cnt = 0; busy_cnt = 0; blk_cnt = 0;
    endtask

    // One clock: sample outputs and handshakes mid-cycle, then advance drivers after the edge.
    task automatic tick();
        logic [NR-1:0] fire;
        ent_t e;
        @(negedge clk);
        fire = i_valid & i_ready;
        rdy0_cnt += int'(i_ready[0]);
        busy_cnt += int'(o_busy);
        if (i_ready[1] && rq[0].size() > 0) blk_cnt++;
        if (o_write_en) begin
            wr_cnt++;
            last_wr = tk;
            if (first_wr < 0) first_wr = tk;
            if (exp_q.size() == 0) begin
                chk("spurious_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("o_data", o_data, e.data);
                chk("o_last", o_last, e.last);
                chk("o_grant", o_grant, e.idx);
                if (e.last) exp_cnt = exp_cnt + 1'b1;
                chk("o_pkt_count", o_pkt_count, exp_cnt);
            end
        end
        @(posedge clk);
        #1;
        tk++;
        for (int k = 0; k < NR; k++) begin
            if (fire[k]) begin
                void'(rq[k].pop_front());
                if (rq[k].size() > 0) hcnt[k] = rq[k][0].hold;
            end else if (hcnt[k] > 0) begin
                hcnt[k]--;
            end
        end
        drive();
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() > 0 || rq[0].size() > 0 || rq[1].size() > 0 ||
                rq[2].size() > 0 || rq[3].size() > 0) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) chk("drain_timeout", 1, 0);
        tick();
        tick();
    endtask

    task automatic flush();
        for (int k = 0; k < NR; k++) begin
            rq[k].delete();
            hcnt[k] = 0;
        end
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush();
        exp_q.delete();
        exp_cnt = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; o_ready = 1'b1; i_valid = '0; i_data = '0; i_last = '0;
        exp_cnt = '0;
        for (int k = 0; k < NR; k++) hcnt[k] = 0;
        clr_stats();

        // reset values
        tick(); tick();
        chk("rst_write_en", o_write_en, 0);
        chk("rst_data", o_data, 0);
        chk("rst_grant", o_grant, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_count", o_pkt_count, 0);
        rst = 1'b0;
        #1;
        chk("rst_i_ready", i_ready, 0);

        // 3-word packet from requester 0
        clr_stats();
        push(0, 36'hA, 1'b0, 0); push(0, 36'hB, 1'b0, 0); push(0, 36'hC, 1'b1, 0);
        expect_wr(0, 36'hA, 1'b0); expect_wr(0, 36'hB, 1'b0); expect_wr(0, 36'hC, 1'b1);
        drain();
        chk("t1_ready_cycles", rdy0_cnt, 3);
        chk("t1_write_cycles", wr_cnt, 3);
        chk("t1_busy_cycles", busy_cnt, 2);
        chk("t1_pkt_count", o_pkt_count, 1);

        // all requesters streaming single-word packets
        do_reset();
        clr_stats();
        for (int j = 0; j < 2; j++)
            for (int k = 0; k < NR; k++) begin
                push(k, mk(k, j), 1'b1, 0);
                expect_wr(k, mk(k, j), 1'b1);
            end
        drain();
        chk("t2_writes", wr_cnt, 8);
        chk("t2_no_bubbles", last_wr - first_wr + 1, 8);

        // locked owner stalls for two cycles; requester 1 must wait
        clr_stats();
        push(1, mk(1, 9), 1'b1, 0);
        push(0, mk(0, 0), 1'b0, 0); push(0, mk(0, 1), 1'b0, 0);
        push(0, mk(0, 2), 1'b0, 2); push(0, mk(0, 3), 1'b1, 0);
        for (int j = 0; j < 4; j++) expect_wr(0, mk(0, j), j == 3);
        expect_wr(1, mk(1, 9), 1'b1);
        drain();
        chk("t3_writes", wr_cnt, 5);
        chk("t3_span", last_wr - first_wr + 1, 7);
        chk("t3_req1_blocked", blk_cnt, 0);

        // FIFO backpressure mid-packet
        for (int j = 0; j < 6; j++) begin
            push(2, mk(2, 20 + j), j == 5, 0);
            expect_wr(2, mk(2, 20 + j), j == 5);
        end
        tick();
        o_ready = 1'b0;
        clr_stats();
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("t4_i_ready_low", i_ready[2], 0);
            tick();
        end
        o_ready = 1'b1;
        tick();
        chk("t4_one_write_in_stall", wr_cnt, 1);
        drain();

        // reset on the second word of a 5-word packet
        for (int j = 0; j < 5; j++) begin
            push(1, mk(1, 40 + j), j == 4, 0);
            expect_wr(1, mk(1, 40 + j), j == 4);
        end
        tick();
        rst = 1'b1;
        flush();
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        tick();
        exp_cnt = '0;
        chk("t5_write_en", o_write_en, 0);
        chk("t5_data", o_data, 0);
        chk("t5_last", o_last, 0);
        chk("t5_grant", o_grant, 0);
        chk("t5_busy", o_busy, 0);
        chk("t5_count", o_pkt_count, 0);
        chk("t5_i_ready", i_ready, 0);
        rst = 1'b0;
        // pointer back at 0: req0 wins over req3, then req2's packet
        push(3, mk(3, 50), 1'b1, 0);
        push(0, mk(0, 50), 1'b1, 0);
        push(2, mk(2, 50), 1'b0, 0); push(2, mk(2, 51), 1'b1, 0);
        expect_wr(0, mk(0, 50), 1'b1);
        expect_wr(2, mk(2, 50), 1'b0); expect_wr(2, mk(2, 51), 1'b1);
        expect_wr(3, mk(3, 50), 1'b1);
        drain();
        chk("t5_exp_empty", exp_q.size(), 0);

        // packet counter wraps
        do_reset();
        for (int j = 0; j < 15; j++) begin
            push(0, mk(0, 60 + j), 1'b1, 0);
            expect_wr(0, mk(0, 60 + j), 1'b1);
        end
        drain();
        chk("t6_count_max", o_pkt_count, 15);
        push(0, mk(0, 99), 1'b1, 0);
        expect_wr(0, mk(0, 99), 1'b1);
        drain();
        chk("t6_count_wrap", o_pkt_count, 0);
        chk("final_exp_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
